instr_encoder: RTL and testbench

Instruction encoder for the MIPS-32 core: the inverse of the control unit's opcode decode. Accepts one instruction per handshake as an instruction kind plus operand fields, packs it into a 32-bit MIPS word using the same opcode assignments the control unit decodes, and emits the word with its instruction-memory address. It sits between the program loader/testbench stream and instruction-memory write port. It tracks the program counter, so absolute branch and jump targets resolve into PC-relative and pseudo-direct encodings.

---
 rtl/mips_isa_pkg.sv | 58 +++++
 rtl/instr_encoder_if.sv | 35 +++
 rtl/instr_field_pack.sv | 40 ++++
 rtl/instr_encoder.sv | 105 ++++++++++
 tb/tb_instr_encoder.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/mips_isa_pkg.sv
// rtl/mips_isa_pkg.sv - MIPS-32 instruction kinds, opcodes and field widths
// Opcode constants are shared with the control unit's decode.
package mips_isa_pkg;

   localparam int OP_W    = 6;
   localparam int REG_W   = 5;
   localparam int FUNCT_W = 6;
   localparam int IMM_W   = 16;
   localparam int TGT_W   = 26;
   localparam int KIND_W  = 4;

   typedef enum logic [KIND_W-1:0] {
      KIND_R    = 4'd0,
      KIND_ADDI = 4'd1,
      KIND_SUBI = 4'd2,
      KIND_ANDI = 4'd3,
      KIND_BEQ  = 4'd4,
      KIND_BNE  = 4'd5,
      KIND_BGT  = 4'd6,
      KIND_BGE  = 4'd7,
      KIND_BLE  = 4'd8,
      KIND_LW   = 4'd9,
      KIND_SW   = 4'd10,
      KIND_J    = 4'd11
   } kind_e;

   localparam logic [OP_W-1:0] OP_R    = 6'b000000;
   localparam logic [OP_W-1:0] OP_ADDI = 6'b001000;
   localparam logic [OP_W-1:0] OP_SUBI = 6'b001001;
   localparam logic [OP_W-1:0] OP_ANDI = 6'b001100;
   localparam logic [OP_W-1:0] OP_BEQ  = 6'b000100;
   localparam logic [OP_W-1:0] OP_BNE  = 6'b000101;
   localparam logic [OP_W-1:0] OP_BGT  = 6'b000110;
   localparam logic [OP_W-1:0] OP_BGE  = 6'b000111;
   localparam logic [OP_W-1:0] OP_BLE  = 6'b001011;
   localparam logic [OP_W-1:0] OP_LW   = 6'b100011;
   localparam logic [OP_W-1:0] OP_SW   = 6'b101011;
   localparam logic [OP_W-1:0] OP_J    = 6'b000010;

   // Illegal kinds map to OP_R; callers flag them separately.
   function automatic logic [OP_W-1:0] opcode_of(input logic [KIND_W-1:0] kind);
      case (kind)
         KIND_ADDI: opcode_of = OP_ADDI;
         KIND_SUBI: opcode_of = OP_SUBI;
         KIND_ANDI: opcode_of = OP_ANDI;
         KIND_BEQ:  opcode_of = OP_BEQ;
         KIND_BNE:  opcode_of = OP_BNE;
         KIND_BGT:  opcode_of = OP_BGT;
         KIND_BGE:  opcode_of = OP_BGE;
         KIND_BLE:  opcode_of = OP_BLE;
         KIND_LW:   opcode_of = OP_LW;
         KIND_SW:   opcode_of = OP_SW;
         KIND_J:    opcode_of = OP_J;
         default:   opcode_of = OP_R;
      endcase
   endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// rtl/instr_encoder_if.sv - instruction-in / word-out stream bundle
// master is the loader side, slave is the encoder.
interface instr_encoder_if;
   import mips_isa_pkg::*;

   logic                in_valid;
   logic                in_ready;
   logic [KIND_W-1:0]   in_kind;
   logic [REG_W-1:0]    in_rs;
   logic [REG_W-1:0]    in_rt;
   logic [REG_W-1:0]    in_rd;
   logic [REG_W-1:0]    in_shamt;
   logic [FUNCT_W-1:0]  in_funct;
   logic [IMM_W-1:0]    in_imm;
   logic [31:0]         in_target;
   logic                out_valid;
   logic                out_ready;
   logic [31:0]         out_addr;
   logic [31:0]         out_word;

   modport master (
      output in_valid, in_kind, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm, in_target,
      input  in_ready,
      input  out_valid, out_addr, out_word,
      output out_ready
   );

   modport slave (
      input  in_valid, in_kind, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm, in_target,
      output in_ready,
      output out_valid, out_addr, out_word,
      input  out_ready
   );

endinterface

// File: rtl/instr_field_pack.sv
// rtl/instr_field_pack.sv - combinational packing of kind + fields into a MIPS word
// Branch offset and jump target arrive already resolved.
module instr_field_pack
   import mips_isa_pkg::*;
(
   input  logic [KIND_W-1:0]  kind,
   input  logic [REG_W-1:0]   rs,
   input  logic [REG_W-1:0]   rt,
   input  logic [REG_W-1:0]   rd,
   input  logic [REG_W-1:0]   shamt,
   input  logic [FUNCT_W-1:0] funct,
   input  logic [IMM_W-1:0]   imm,
   input  logic [IMM_W-1:0]   off16,
   input  logic [TGT_W-1:0]   tgt26,
   output logic [31:0]        word,
   output logic               illegal
);

   logic [OP_W-1:0] op;

   assign op = opcode_of(kind);

   always_comb begin
      word    = '0;
      illegal = 1'b0;
      case (kind)
         KIND_R:
            word = {OP_R, rs, rt, rd, shamt, funct};
         KIND_ADDI, KIND_SUBI, KIND_ANDI, KIND_LW, KIND_SW:
            word = {op, rs, rt, imm};
         KIND_BEQ, KIND_BNE, KIND_BGT, KIND_BGE, KIND_BLE:
            word = {op, rs, rt, off16};
         KIND_J:
            word = {op, tgt26};
         default:
            illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - MIPS-32 instruction encoder with PC tracking
// ENC_BRANCH_RESOLVE_EN: resolve absolute branch/jump targets with range checks.
module instr_encoder
   import mips_isa_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          CNT_W     = 16
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear_pc,
   instr_encoder_if.slave    bus,
   output logic              err_illegal,
   output logic              err_range,
   output logic [CNT_W-1:0]  word_count
);

   logic [31:0]      pc;
   logic [IMM_W-1:0] off16;
   logic [TGT_W-1:0] tgt26;
   logic             range_err;
   logic             illegal;
   logic [31:0]      packed_word;
   logic             accept;

   assign bus.in_ready = (!bus.out_valid || bus.out_ready) && !clear_pc;
   assign accept       = bus.in_valid && bus.in_ready;

`ifdef ENC_BRANCH_RESOLVE_EN
   logic [31:0] pc_next4;
   logic [31:0] off32;
   logic        is_branch;
   logic        is_jump;
   logic        misaligned;

   assign pc_next4   = pc + 32'd4;
   assign off32      = $signed(bus.in_target - pc_next4) >>> 2;
   assign is_branch  = bus.in_kind inside {KIND_BEQ, KIND_BNE, KIND_BGT, KIND_BGE, KIND_BLE};
   assign is_jump    = (bus.in_kind == KIND_J);
   assign misaligned = |bus.in_target[1:0];
   assign off16      = off32[15:0];
   assign tgt26      = bus.in_target[27:2];

   // Offset fits in 16 bits only when bits 31:15 are a pure sign extension.
   always_comb begin
      range_err = 1'b0;
      if (is_branch)
         range_err = misaligned || !((&off32[31:15]) || !(|off32[31:15]));
      else if (is_jump)
         range_err = misaligned || (bus.in_target[31:28] != pc_next4[31:28]);
   end
`else
   assign off16     = bus.in_imm;
   assign tgt26     = bus.in_target[25:0];
   assign range_err = 1'b0;
`endif

   instr_field_pack u_pack (
      .kind    (bus.in_kind),
      .rs      (bus.in_rs),
      .rt      (bus.in_rt),
      .rd      (bus.in_rd),
      .shamt   (bus.in_shamt),
      .funct   (bus.in_funct),
      .imm     (bus.in_imm),
      .off16   (off16),
      .tgt26   (tgt26),
      .word    (packed_word),
      .illegal (illegal)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc            <= BASE_ADDR;
         word_count    <= '0;
         bus.out_valid <= 1'b0;
         bus.out_addr  <= '0;
         bus.out_word  <= '0;
         err_illegal   <= 1'b0;
         err_range     <= 1'b0;
      end else begin
         err_illegal <= accept && illegal;
         err_range   <= accept && !illegal && range_err;

         if (clear_pc) begin
            pc         <= BASE_ADDR;
            word_count <= '0;
         end

         if (bus.out_valid && bus.out_ready)
            bus.out_valid <= 1'b0;

         // Dropped accepts fall through, so a same-cycle transfer still clears out_valid.
         if (accept && !illegal && !range_err) begin
            bus.out_valid <= 1'b1;
            bus.out_addr  <= pc;
            bus.out_word  <= packed_word;
            pc            <= pc + 32'd4;
            if (word_count != '1)
               word_count <= word_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - directed self-checking bench for instr_encoder
module tb_instr_encoder;
   import mips_isa_pkg::*;

   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             clear_pc;
   logic             err_illegal;
   logic             err_range;
   logic [CNT_W-1:0] word_count;

   int n_checks = 0;
   int n_fails  = 0;

   instr_encoder_if bus ();

   instr_encoder #(.BASE_ADDR(32'h0000_0000), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .clear_pc    (clear_pc),
      .bus         (bus),
      .err_illegal (err_illegal),
      .err_range   (err_range),
      .word_count  (word_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input logic [3:0] kind, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] shamt, input logic [5:0] funct,
                      input logic [15:0] imm, input logic [31:0] target);
      bus.in_kind   = kind;
      bus.in_rs     = rs;
      bus.in_rt     = rt;
      bus.in_rd     = rd;
      bus.in_shamt  = shamt;
      bus.in_funct  = funct;
      bus.in_imm    = imm;
      bus.in_target = target;
      bus.in_valid  = 1'b1;
   endtask

   task automatic check_word(input string tag, input logic [31:0] addr, input logic [31:0] word,
                             input logic [31:0] cnt);
      check({tag, "_valid"}, {31'b0, bus.out_valid}, 32'd1);
      check({tag, "_addr"},  bus.out_addr, addr);
      check({tag, "_word"},  bus.out_word, word);
      check({tag, "_count"}, {28'b0, word_count}, cnt);
   endtask

   initial begin
      rst_n         = 1'b0;
      clear_pc      = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      put(4'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 32'd0);
      bus.in_valid  = 1'b0;
      step();
      step();
      check("rst_valid", {31'b0, bus.out_valid}, 32'd0);
      check("rst_addr",  bus.out_addr, 32'd0);
      check("rst_word",  bus.out_word, 32'd0);
      check("rst_count", {28'b0, word_count}, 32'd0);
      check("rst_errs",  {30'b0, err_illegal, err_range}, 32'd0);
      rst_n = 1'b1;
      #1;
      check("rst_ready", {31'b0, bus.in_ready}, 32'd1);

      // ADDI rs=1 rt=2 imm=5
      put(KIND_ADDI, 5'd1, 5'd2, 5'd9, 5'd0, 6'd0, 16'h0005, 32'd0);
      step();
      bus.in_valid = 1'b0;
      check_word("addi", 32'd0, 32'h2022_0005, 32'd1);
      step();
      check("addi_drop", {31'b0, bus.out_valid}, 32'd0);

      // R add under back-pressure, with ANDI pending
      bus.out_ready = 1'b0;
      put(KIND_R, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100000, 16'hFFFF, 32'd0);
      step();
      put(KIND_ANDI, 5'd3, 5'd4, 5'd0, 5'd0, 6'd0, 16'h00FF, 32'd0);
      for (int i = 0; i < 3; i++) begin
         check("stall_ready", {31'b0, bus.in_ready}, 32'd0);
         check_word("stall_r", 32'd4, 32'h0022_1820, 32'd2);
         step();
      end
      bus.out_ready = 1'b1;
      #1;
      check("release_ready", {31'b0, bus.in_ready}, 32'd1);
      step();
      bus.in_valid = 1'b0;
      check_word("andi", 32'd8, 32'h3064_00FF, 32'd3);
      step();
      check("andi_drop", {31'b0, bus.out_valid}, 32'd0);

      // illegal kind 13
      put(4'd13, 5'd1, 5'd1, 5'd1, 5'd0, 6'd0, 16'd0, 32'd0);
      step();
      bus.in_valid = 1'b0;
      check("ill_pulse", {31'b0, err_illegal}, 32'd1);
      check("ill_range", {31'b0, err_range}, 32'd0);
      check("ill_valid", {31'b0, bus.out_valid}, 32'd0);
      step();
      check("ill_end", {31'b0, err_illegal}, 32'd0);

      // backward BEQ at pc=12: target 4 -> off -3, raw imm also FFFD
      put(KIND_BEQ, 5'd1, 5'd0, 5'd0, 5'd0, 6'd0, 16'hFFFD, 32'h0000_0004);
      step();
      bus.in_valid = 1'b0;
      check_word("beq_back", 32'd12, 32'h1020_FFFD, 32'd4);
      step();

`ifdef ENC_BRANCH_RESOLVE_EN
      // pc=16: off 0x8000 is one past the positive limit
      put(KIND_BEQ, 5'd1, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 32'h0002_0014);
      step();
      bus.in_valid = 1'b0;
      check("beq_far_err", {31'b0, err_range}, 32'd1);
      check("beq_far_valid", {31'b0, bus.out_valid}, 32'd0);
      check("beq_far_count", {28'b0, word_count}, 32'd4);
      step();
      check("beq_far_end", {31'b0, err_range}, 32'd0);
      put(KIND_BNE, 5'd1, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 32'h0000_0022);
      step();
      bus.in_valid = 1'b0;
      check("bne_mis_err", {31'b0, err_range}, 32'd1);
      check("bne_mis_valid", {31'b0, bus.out_valid}, 32'd0);
      step();
`endif
      // pc=16: off 0x7FFF is the positive limit
      put(KIND_BEQ, 5'd1, 5'd0, 5'd0, 5'd0, 6'd0, 16'h7FFF, 32'h0002_0010);
      step();
      bus.in_valid = 1'b0;
      check_word("beq_max", 32'd16, 32'h1020_7FFF, 32'd5);
      check("beq_max_err", {31'b0, err_range}, 32'd0);
      step();

      put(KIND_J, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 32'h0000_0040);
      step();
      bus.in_valid = 1'b0;
`ifdef ENC_BRANCH_RESOLVE_EN
      check_word("j", 32'd20, 32'h0800_0010, 32'd6);
`else
      check_word("j", 32'd20, 32'h0800_0040, 32'd6);
`endif
      step();
`ifdef ENC_BRANCH_RESOLVE_EN
      put(KIND_J, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 32'h1000_0000);
      step();
      bus.in_valid = 1'b0;
      check("j_region_err", {31'b0, err_range}, 32'd1);
      check("j_region_valid", {31'b0, bus.out_valid}, 32'd0);
      step();
      check("j_region_end", {31'b0, err_range}, 32'd0);
`endif

      // back-to-back at full throughput
      put(KIND_LW, 5'd29, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0004, 32'd0);
      step();
      check_word("lw", 32'd24, 32'h8FA8_0004, 32'd7);
      put(KIND_SW, 5'd29, 5'd8, 5'd0, 5'd0, 6'd0, 16'hFFF0, 32'd0);
      step();
      check_word("sw", 32'd28, 32'hAFA8_FFF0, 32'd8);
      put(KIND_SUBI, 5'd5, 5'd6, 5'd0, 5'd0, 6'd0, 16'h1234, 32'd0);
      step();
      bus.in_valid = 1'b0;
      check_word("subi", 32'd32, 32'h24A6_1234, 32'd9);
      step();

      // clear_pc leaves a held word alone and blocks accepts
      bus.out_ready = 1'b0;
      put(KIND_ADDI, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0005, 32'd0);
      step();
      check_word("pre_clr", 32'd36, 32'h2022_0005, 32'd10);
      clear_pc = 1'b1;
      step();
      check_word("clr_hold", 32'd36, 32'h2022_0005, 32'd0);
      bus.out_ready = 1'b1;
      #1;
      check("clr_ready", {31'b0, bus.in_ready}, 32'd0);
      step();
      check("clr_noacc", {31'b0, bus.out_valid}, 32'd0);
      clear_pc = 1'b0;
      step();
      check_word("post_clr", 32'd0, 32'h2022_0005, 32'd1);

      // word_count saturates
      for (int i = 0; i < 16; i++) step();
      bus.in_valid = 1'b0;
      check_word("sat", 32'd64, 32'h2022_0005, 32'd15);
      step();

      // reset mid-transfer discards the pending word
      bus.out_ready = 1'b0;
      put(KIND_ADDI, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0005, 32'd0);
      step();
      bus.in_valid = 1'b0;
      check_word("pre_rst", 32'd68, 32'h2022_0005, 32'd15);
      rst_n = 1'b0;
      step();
      check("mid_rst_valid", {31'b0, bus.out_valid}, 32'd0);
      check("mid_rst_addr", bus.out_addr, 32'd0);
      check("mid_rst_count", {28'b0, word_count}, 32'd0);
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      put(KIND_ADDI, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0005, 32'd0);
      step();
      bus.in_valid = 1'b0;
      check_word("post_rst", 32'd0, 32'h2022_0005, 32'd1);
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
